// File: rtl/store_buffer.sv
// Posted-write store buffer between a CPU and a single-ported memory; loads go out as memory reads.
// Optional macro SB_FORWARD_EN: loads that hit a buffered store are answered from the buffer.
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_we,
   input  logic          cpu_re,
   input  logic [DW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_stall,
   output logic          mem_req,
   output logic          mem_we,
   output logic [DW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_ack,
   input  logic [DW-1:0] mem_rdata
);
   localparam int          AW   = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] addr_q [DEPTH];
   logic [DW-1:0] data_q [DEPTH];
   logic [AW-1:0] head_q, head_d, tail_q, tail_d;
   logic [AW:0]   count_q, count_d;
   logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [DW-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;

   logic          ack, load, enq, deq, fwd_hit, rd_start;
   logic [DW-1:0] fwd_data, word_addr;
   logic          unused_addr_lsb;

   // an acknowledge arriving during reset belongs to an abandoned transfer
   assign ack             = mem_ack & ~reset;
   assign load            = cpu_re & ~cpu_we;
   assign word_addr       = {cpu_addr[DW-1:2], 2'b00};
   assign unused_addr_lsb = ^cpu_addr[1:0];
   assign enq             = cpu_we & (count_q != FULL);
   assign deq             = (state_q == WRITE) & ack;

`ifdef SB_FORWARD_EN
   // scan oldest to newest so the youngest matching store wins
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (((AW+1)'(i) < count_q) && (addr_q[head_q + AW'(i)] == word_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = data_q[head_q + AW'(i)];
         end
      end
   end
   assign rd_start = load & ~fwd_hit;
`else
   assign fwd_hit  = 1'b0;
   assign fwd_data = '0;
   assign rd_start = load & (count_q == '0);
`endif

   always_comb begin
      cpu_stall = 1'b0;
      cpu_rdata = '0;
      if (cpu_we) begin
         cpu_stall = (count_q == FULL);
      end else if (cpu_re) begin
         if (fwd_hit)
            cpu_rdata = fwd_data;
         else if ((state_q == READ) && ack)
            cpu_rdata = mem_rdata;
         else
            cpu_stall = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      head_d      = deq ? head_q + AW'(1) : head_q;
      tail_d      = enq ? tail_q + AW'(1) : tail_q;
      count_d     = count_q + (AW+1)'(enq) - (AW+1)'(deq);
      case (state_q)
         IDLE: begin
            if (rd_start) begin
               state_d     = READ;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = word_addr;
               mem_wdata_d = '0;
            end else if (count_q != '0) begin
               state_d     = WRITE;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = addr_q[head_q];
               mem_wdata_d = data_q[head_q];
            end
         end
         WRITE, READ: begin
            if (ack) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (enq && !reset) begin
         addr_q[tail_q] <= word_addr;
         data_q[tail_q] <= cpu_wdata;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: queue-based reference model checked every cycle plus directed scenarios.
// Follows SB_FORWARD_EN the same way as the design.
module tb_store_buffer;
   localparam int DEPTH = 4;
   localparam int DW    = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          cpu_we, cpu_re, mem_ack;
   logic [DW-1:0] cpu_addr, cpu_wdata, mem_rdata;
   logic [DW-1:0] cpu_rdata, mem_addr, mem_wdata;
   logic          cpu_stall, mem_req, mem_we;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   store_buffer #(.DEPTH(DEPTH), .DW(DW)) dut (
      .clk(clk), .reset(reset),
      .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   function automatic void chk_w(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
      end
   endfunction

   function automatic void chk_b(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0b, expected %0b at %0t", name, got, exp, $time);
      end
   endfunction

   // Reference model: the buffer is a plain queue of pending (word address, data) stores.
   typedef struct packed {
      logic [DW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;
   ent_t sbq[$];
   logic prev_reset = 1'b1;

   always @(negedge clk) begin : compare
      logic [DW-1:0] waddr, fwd, exp_rdata;
      logic          ld, hit, rd_done, full, exp_stall;
      waddr = {cpu_addr[DW-1:2], 2'b00};
      ld    = cpu_re && !cpu_we;
      hit   = 1'b0;
      fwd   = '0;
`ifdef SB_FORWARD_EN
      foreach (sbq[i]) if (sbq[i].a == waddr) begin
         hit = 1'b1;
         fwd = sbq[i].d;
      end
`endif
      full      = (sbq.size() == DEPTH);
      rd_done   = mem_req && !mem_we && mem_ack && !reset;
      exp_stall = cpu_we ? full : (ld && !hit && !rd_done);
      exp_rdata = (ld && hit) ? fwd : (rd_done ? mem_rdata : '0);
      chk_b("model_cpu_stall", cpu_stall, exp_stall);
      chk_w("model_cpu_rdata", cpu_rdata, exp_rdata);
      if (prev_reset) chk_b("model_req_after_reset", mem_req, 1'b0);
      if (mem_req) chk_b("model_addr_lsb_zero", |mem_addr[1:0], 1'b0);
      if (mem_req && mem_we) begin
         chk_b("model_write_has_entry", sbq.size() > 0, 1'b1);
         if (sbq.size() > 0) begin
            chk_w("model_write_addr", mem_addr, sbq[0].a);
            chk_w("model_write_data", mem_wdata, sbq[0].d);
         end
      end
      if (mem_req && !mem_we) begin
         chk_b("model_read_needs_load", ld, 1'b1);
         chk_w("model_read_addr", mem_addr, waddr);
`ifndef SB_FORWARD_EN
         chk_b("model_read_after_drain", sbq.size() == 0, 1'b1);
`endif
      end
      if (reset) begin
         sbq.delete();
      end else begin
         if (mem_req && mem_we && mem_ack && sbq.size() > 0) void'(sbq.pop_front());
         if (cpu_we && !full) sbq.push_back('{a: waddr, d: cpu_wdata});
      end
      prev_reset = reset;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      cpu_we = 1'b0; cpu_re = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      mem_ack = 1'b0; mem_rdata = '0;
   endtask

   task automatic store(input logic [DW-1:0] a, input logic [DW-1:0] d);
      cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
      #1;
      chk_b("store_accept", cpu_stall, 1'b0);
      tick();
      cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
   endtask

   task automatic wait_req(input logic we, input string name);
      int n = 0;
      while (!(mem_req && (mem_we == we)) && n < 20) begin
         tick();
         n++;
      end
      chk_b({name, "_transfer_started"}, mem_req && (mem_we == we), 1'b1);
   endtask

   task automatic ack_pulse(input logic [DW-1:0] rd);
      mem_rdata = rd; mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0; mem_rdata = '0;
   endtask

   task automatic drain(input logic [DW-1:0] a, input logic [DW-1:0] d, input string name);
      wait_req(1'b1, name);
      chk_w({name, "_addr"}, mem_addr, a);
      chk_w({name, "_data"}, mem_wdata, d);
      ack_pulse('0);
   endtask

   initial begin
      #100000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      idle_in();
      tick(); tick();
      reset = 1'b0;
      chk_b("reset_mem_req", mem_req, 1'b0);
      chk_b("reset_stall", cpu_stall, 1'b0);
      chk_w("reset_rdata", cpu_rdata, 32'h0);

      // single store, memory holds off, transfer must stay stable
      store(32'h10, 32'hAA);
      wait_req(1'b1, "wr10");
      for (int i = 0; i < 3; i++) begin
         chk_b("wr10_we", mem_we, 1'b1);
         chk_w("wr10_addr", mem_addr, 32'h10);
         chk_w("wr10_data", mem_wdata, 32'hAA);
         tick();
      end
      ack_pulse('0);
      for (int i = 0; i < 3; i++) begin
         chk_b("wr10_drained_idle", mem_req, 1'b0);
         tick();
      end

      // five stores into a four-entry buffer
      for (int k = 0; k < 4; k++) store(32'h100 + 32'(4 * k), 32'h1000 + 32'(k));
      cpu_we = 1'b1; cpu_addr = 32'h110; cpu_wdata = 32'h1004;
      #1;
      chk_b("full_stall", cpu_stall, 1'b1);
      tick();
      chk_b("full_stall_hold", cpu_stall, 1'b1);
      chk_b("full_write_busy", mem_req && mem_we, 1'b1);
      chk_w("full_head_addr", mem_addr, 32'h100);
      mem_ack = 1'b1;
      #1;
      chk_b("full_stall_on_ack", cpu_stall, 1'b1);
      tick();
      mem_ack = 1'b0;
      #1;
      chk_b("full_accept_after_ack", cpu_stall, 1'b0);
      tick();
      cpu_we = 1'b0;
      for (int k = 1; k < 5; k++) drain(32'h100 + 32'(4 * k), 32'h1000 + 32'(k), "fifo_order");

      // load miss behind an in-flight write
      store(32'h30, 32'h77);
      wait_req(1'b1, "wr30");
      cpu_re = 1'b1; cpu_addr = 32'h40;
      #1;
      chk_b("miss_stall", cpu_stall, 1'b1);
      tick();
      chk_b("write_before_read", mem_we, 1'b1);
      chk_w("write_before_read_addr", mem_addr, 32'h30);
      ack_pulse('0);
      wait_req(1'b0, "rd40");
      chk_w("rd40_addr", mem_addr, 32'h40);
      chk_b("rd40_stall", cpu_stall, 1'b1);
      mem_ack = 1'b1; mem_rdata = 32'h5A;
      #1;
      chk_w("rd40_rdata", cpu_rdata, 32'h5A);
      chk_b("rd40_stall_done", cpu_stall, 1'b0);
      tick();
      idle_in();
      #1;
      chk_b("rd40_idle", mem_req, 1'b0);
      chk_w("rd40_rdata_zero", cpu_rdata, 32'h0);

      // reset in the middle of a write with three entries buffered
      store(32'h50, 32'h1); store(32'h54, 32'h2); store(32'h58, 32'h3);
      wait_req(1'b1, "wr50");
      reset = 1'b1; mem_ack = 1'b1;
      tick();
      chk_b("reset_mid_write_req", mem_req, 1'b0);
      reset = 1'b0;
      tick();
      mem_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk_b("no_stale_write", mem_req, 1'b0);
         tick();
      end

      // enqueue and dequeue in the same cycle leave the occupancy unchanged
      store(32'h80, 32'hA0); store(32'h84, 32'hA4); store(32'h88, 32'hA8);
      wait_req(1'b1, "wr80");
      chk_w("wr80_addr", mem_addr, 32'h80);
      cpu_we = 1'b1; cpu_addr = 32'h8C; cpu_wdata = 32'hAC; mem_ack = 1'b1;
      #1;
      chk_b("enq_deq_same_cycle", cpu_stall, 1'b0);
      tick();
      cpu_we = 1'b0; mem_ack = 1'b0;
      store(32'h90, 32'hB0);
      cpu_we = 1'b1; cpu_addr = 32'h94; cpu_wdata = 32'hB4;
      #1;
      chk_b("count_held_full", cpu_stall, 1'b1);
      tick();
      cpu_we = 1'b0;
      drain(32'h84, 32'hA4, "enqdeq_drain");
      drain(32'h88, 32'hA8, "enqdeq_drain");
      drain(32'h8C, 32'hAC, "enqdeq_drain");
      drain(32'h90, 32'hB0, "enqdeq_drain");

      // two stores to one word, then a load of that word
      store(32'h20, 32'h11);
      store(32'h20, 32'h22);
      cpu_re = 1'b1; cpu_addr = 32'h20;
`ifdef SB_FORWARD_EN
      #1;
      for (int i = 0; i < 3; i++) begin
         chk_w("fwd_rdata", cpu_rdata, 32'h22);
         chk_b("fwd_no_stall", cpu_stall, 1'b0);
         chk_b("fwd_no_read", mem_req && !mem_we, 1'b0);
         tick();
      end
      idle_in();
      drain(32'h20, 32'h11, "fwd_drain");
      drain(32'h20, 32'h22, "fwd_drain");
`else
      #1;
      chk_b("load_waits_drain", cpu_stall, 1'b1);
      drain(32'h20, 32'h11, "pre_load_drain");
      chk_b("load_waits_second", cpu_stall, 1'b1);
      drain(32'h20, 32'h22, "pre_load_drain");
      wait_req(1'b0, "rd20");
      chk_w("rd20_addr", mem_addr, 32'h20);
      chk_b("rd20_stall", cpu_stall, 1'b1);
      mem_ack = 1'b1; mem_rdata = 32'hBEEF;
      #1;
      chk_w("rd20_rdata", cpu_rdata, 32'hBEEF);
      chk_b("rd20_stall_done", cpu_stall, 1'b0);
      tick();
      idle_in();
`endif
      tick(); tick();
      chk_b("final_idle", mem_req, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
